// File: rtl/parking_gate_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parking_gate_if : lane request/response and Parking event bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface parking_gate_if #(
  parameter int NUM_LANES = 4
);
  logic [NUM_LANES-1:0] ent_req;
  logic [NUM_LANES-1:0] ent_uni;
  logic [NUM_LANES-1:0] ext_req;
  logic [NUM_LANES-1:0] ext_uni;
  logic                 illegal_enter;
  logic                 illegal_exit;
  logic                 car_entered;
  logic                 is_uni_car_entered;
  logic                 car_exited;
  logic                 is_uni_car_exited;
  logic [NUM_LANES-1:0] ent_grant;
  logic [NUM_LANES-1:0] ent_deny;
  logic [NUM_LANES-1:0] ext_grant;
  logic [NUM_LANES-1:0] ext_deny;

  // master: barriers plus Parking; slave: the scheduler
  modport master (
    output ent_req, ent_uni, ext_req, ext_uni, illegal_enter, illegal_exit,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    input  ent_grant, ent_deny, ext_grant, ext_deny
  );

  modport slave (
    input  ent_req, ent_uni, ext_req, ext_uni, illegal_enter, illegal_exit,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    output ent_grant, ent_deny, ext_grant, ext_deny
  );
endinterface
`default_nettype wire

// File: rtl/parking_gate_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// parking_gate_scheduler : round-robin entry/exit lane front end for Parking
// Rev 1.0
// ---------------------------------------------------------------------------
module parking_gate_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  parking_gate_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] ent_served_cnt,
  output logic [CNT_W-1:0] ent_denied_cnt,
  output logic [CNT_W-1:0] ext_served_cnt,
  output logic [CNT_W-1:0] ext_denied_cnt
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IDX_W  = LANE_W + 1;

  // Gray-coded so every transition of the normal loop flips a single bit
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ISSUE = 2'b01;
  localparam logic [1:0] S_WAIT  = 2'b11;
  localparam logic [1:0] S_RESP  = 2'b10;

  // index 0 = entry direction, index 1 = exit direction
  logic [1:0][NUM_LANES-1:0] req;
  logic [1:0][NUM_LANES-1:0] uni;
  logic [1:0][NUM_LANES-1:0] grant;
  logic [1:0][NUM_LANES-1:0] deny;
  logic [1:0][CNT_W-1:0]     served;
  logic [1:0][CNT_W-1:0]     denied;
  logic [1:0]                illegal;
  logic [1:0]                car;
  logic [1:0]                car_uni;
  logic [1:0]                active;

  assign req[0]     = bus.ent_req;
  assign req[1]     = bus.ext_req;
  assign uni[0]     = bus.ent_uni;
  assign uni[1]     = bus.ext_uni;
  assign illegal[0] = bus.illegal_enter;
  assign illegal[1] = bus.illegal_exit;

  for (genvar d = 0; d < 2; d++) begin : g_dir
    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [LANE_W-1:0]    lane_q;
    logic [LANE_W-1:0]    ptr_q;
    logic [LANE_W-1:0]    pick;
    logic [IDX_W-1:0]     idx;
    logic                 uni_q;
    logic                 found;
    logic [CNT_W-1:0]     served_q;
    logic [CNT_W-1:0]     denied_q;
    logic                 car_c;
    logic                 car_uni_c;
    logic [NUM_LANES-1:0] grant_c;
    logic [NUM_LANES-1:0] deny_c;

    // first requesting lane at or after the pointer, wrapping past the last lane
    always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      idx   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        idx = {1'b0, ptr_q} + IDX_W'(i);
        if (idx >= IDX_W'(NUM_LANES)) begin
          idx = idx - IDX_W'(NUM_LANES);
        end
        if (!found && req[d][idx[LANE_W-1:0]]) begin
          found = 1'b1;
          pick  = idx[LANE_W-1:0];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= S_IDLE;
        lane_q   <= '0;
        uni_q    <= 1'b0;
        ptr_q    <= '0;
        served_q <= '0;
        denied_q <= '0;
      end else begin
        state_q <= state_d;
        if (state_q == S_IDLE && found) begin
          lane_q <= pick;
          uni_q  <= uni[d][pick];
        end
        if (state_q == S_RESP) begin
          ptr_q <= (lane_q == LANE_W'(NUM_LANES - 1)) ? '0 : lane_q + 1'b1;
          // counters stick at all-ones instead of wrapping
          if (illegal[d]) begin
            if (denied_q != '1) denied_q <= denied_q + 1'b1;
          end else begin
            if (served_q != '1) served_q <= served_q + 1'b1;
          end
        end
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE:  if (found) state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT:  state_d = S_RESP;
        default: state_d = S_IDLE;
      endcase
    end

    always_comb begin
      car_c     = 1'b0;
      car_uni_c = 1'b0;
      grant_c   = '0;
      deny_c    = '0;
      case (state_q)
        S_ISSUE: begin
          car_c     = 1'b1;
          car_uni_c = uni_q;
        end
        S_RESP: begin
          if (illegal[d]) deny_c  = {{(NUM_LANES-1){1'b0}}, 1'b1} << lane_q;
          else            grant_c = {{(NUM_LANES-1){1'b0}}, 1'b1} << lane_q;
        end
        default: ;
      endcase
    end

    assign car[d]     = car_c;
    assign car_uni[d] = car_uni_c;
    assign grant[d]   = grant_c;
    assign deny[d]    = deny_c;
    assign served[d]  = served_q;
    assign denied[d]  = denied_q;
    assign active[d]  = (state_q != S_IDLE);
  end

  assign bus.car_entered        = car[0];
  assign bus.is_uni_car_entered = car_uni[0];
  assign bus.car_exited         = car[1];
  assign bus.is_uni_car_exited  = car_uni[1];
  assign bus.ent_grant          = grant[0];
  assign bus.ent_deny           = deny[0];
  assign bus.ext_grant          = grant[1];
  assign bus.ext_deny           = deny[1];

  assign busy           = |active;
  assign ent_served_cnt = served[0];
  assign ent_denied_cnt = denied[0];
  assign ext_served_cnt = served[1];
  assign ext_denied_cnt = denied[1];

endmodule
`default_nettype wire
